decode_stage: RTL

- Registered, handshaked RV32I instruction decode stage. Successor to the purely combinational field splitter.
- Takes a 32-bit instruction word from fetch and extracts register addresses, opcode and funct fields.
- Classifies the instruction format and produces the fully formed, sign-extended immediate for every format.
- Presents results to the execute/control stage through a valid/ready interface with a 2-entry skid buffer, giving full throughput under back-pressure.

---
 rtl/decode_stage_if.sv | 43 ++++
 rtl/decode_stage.sv | 136 +++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake bundle for decode_stage: input word stream, decoded output stream, flush.
// The perf counters exist only when DECODE_PERF_CNT_EN is defined.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0]     dec_count;
    logic [31:0]     ill_count;
`endif

    // master: fetch/execute environment around the stage; slave: the decode stage itself
    modport master (
        output flush, in_valid, in_instr, out_ready,
        input  in_ready, out_valid, rs1, rs2, rd, opcode, funct3, funct7, imm, fmt, illegal
`ifdef DECODE_PERF_CNT_EN
        , input dec_count, ill_count
`endif
    );

    modport slave (
        input  flush, in_valid, in_instr, out_ready,
        output in_ready, out_valid, rs1, rs2, rd, opcode, funct3, funct7, imm, fmt, illegal
`ifdef DECODE_PERF_CNT_EN
        , output dec_count, ill_count
`endif
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer for full throughput under back-pressure.
// Define DECODE_PERF_CNT_EN to add the dec_count/ill_count performance counters.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input logic          clk,
    input logic          rst_n,
    decode_stage_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    entry_t     dec, head, skid;
    logic       head_valid, skid_valid;
    logic       accept, consume;
    logic [31:0] ins;

    assign ins = bus.in_instr;

    always_comb begin
        // NOTE: every field gets a default before the case statements so no latch is inferred.
        dec        = '0;
        dec.rs1    = RA_W'(ins[19:15]);
        dec.rs2    = RA_W'(ins[24:20]);
        dec.rd     = RA_W'(ins[11:7]);
        dec.opcode = ins[6:0];
        dec.funct3 = ins[14:12];
        dec.funct7 = ins[31:25];
        case (ins[6:0])
            7'b0110011:                                     dec.fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec.fmt = FMT_I;
            7'b0100011:                                     dec.fmt = FMT_S;
            7'b1100011:                                     dec.fmt = FMT_B;
            7'b0110111, 7'b0010111:                         dec.fmt = FMT_U;
            7'b1101111:                                     dec.fmt = FMT_J;
            default: begin
                dec.fmt     = FMT_ILL;
                dec.illegal = 1'b1;
            end
        endcase
        // Signed casts replicate the top immediate bit up to XLEN.
        case (dec.fmt)
            FMT_I:   dec.imm = XLEN'($signed(ins[31:20]));
            FMT_S:   dec.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
            FMT_B:   dec.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            FMT_U:   dec.imm = XLEN'($signed({ins[31:12], 12'b0}));
            FMT_J:   dec.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            default: dec.imm = '0;
        endcase
    end

    // in_ready is the registered inverse of skid occupancy, so it never depends on out_ready.
    assign accept  = bus.in_valid & ~skid_valid;
    assign consume = head_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only; data registers are reset
        // too so the outputs read 0 after reset rather than X.
        if (!rst_n) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head       <= '0;
            skid       <= '0;
        end else if (bus.flush) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (consume) begin
            if (skid_valid) begin
                head       <= skid;
                skid_valid <= 1'b0;
            end else if (accept) begin
                head <= dec;
            end else begin
                head_valid <= 1'b0;
            end
        end else if (accept) begin
            if (head_valid) begin
                skid       <= dec;
                skid_valid <= 1'b1;
            end else begin
                head       <= dec;
                head_valid <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = ~skid_valid;
    assign bus.out_valid = head_valid;
    assign bus.rs1       = head.rs1;
    assign bus.rs2       = head.rs2;
    assign bus.rd        = head.rd;
    assign bus.opcode    = head.opcode;
    assign bus.funct3    = head.funct3;
    assign bus.funct7    = head.funct7;
    assign bus.imm       = head.imm;
    assign bus.fmt       = head.fmt;
    assign bus.illegal   = head.illegal;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] dec_cnt, ill_cnt;

    // Counters follow consumption only; flush leaves them untouched and they wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt <= '0;
            ill_cnt <= '0;
        end else if (consume) begin
            dec_cnt <= dec_cnt + 32'd1;
            if (head.illegal) ill_cnt <= ill_cnt + 32'd1;
        end
    end

    assign bus.dec_count = dec_cnt;
    assign bus.ill_count = ill_cnt;
`endif
endmodule
